ltl_report_collector: RTL
=========================

Name: ltl_report_collector

Overview:
- Downstream stage of an ltl automaton cluster.
- Samples the automaton's report vector once per consumed symbol and tags each non-zero vector with the index of the symbol that produced it.
- Buffers the tagged records in a FIFO that drains to the monitor's report interface through a valid/ready handshake.
- Counts and flags records lost when the FIFO is full.

Parameters:
- NUM_REPORTS, 4: width of the report vector (number of report STEs in the cluster).
- IDX_W, 32: width of the symbol index counter and of the index field in a record.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- DROP_W, 16: width of the dropped-record counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- run  in  1  high in a cycle in which the automaton consumes a symbol.
- report_vec  in  NUM_REPORTS  concatenated automaton report outputs (active_state of report STEs); bit i is report i.
- rec_valid  out  1  FIFO head record is valid.
- rec_ready  in  1  consumer accepts the head this cycle.
- rec_idx  out  IDX_W  symbol index of the head record.
- rec_reports  out  NUM_REPORTS  report bits of the head record.
- fill_level  out  log2(DEPTH)+1  current number of FIFO entries.
- overflow  out  1  sticky; set on the first dropped record.
- drop_count  out  DROP_W  saturating count of dropped records.

Behaviour:
- Reset: all of the following are 0 on the cycle after reset is sampled high.
  - rec_valid, rec_idx, rec_reports, fill_level, overflow, drop_count.
  - Symbol counter sym_cnt, run_q, idx_q.
  - FIFO pointers.
- A reset asserted mid-operation discards all buffered records.
- Symbol indexing:
  - Each cycle with run=1: idx_q <= sym_cnt; sym_cnt <= sym_cnt+1, wrapping modulo 2^IDX_W.
  - run_q <= run every cycle.
  - The first symbol after reset has index 0.
- Alignment: report_vec is registered inside the STEs, so it reflects the symbol consumed in the previous cycle. The collector therefore qualifies it with run_q, not run.
- Capture: in a cycle with run_q=1 and report_vec != 0, a push request is made with record {idx_q, report_vec}.
  - report_vec is ignored when run_q=0 or report_vec=0; no record is created.
- Push acceptance: accept if fill_level < DEPTH, or if a pop happens in the same cycle.
  - This includes simultaneous push and pop while full: count stays DEPTH, ordering is preserved.
- Drop: a push request that is not accepted is discarded.
  - overflow <= 1.
  - drop_count increments, saturating at 2^DROP_W-1 (no wrap).
- Pop: occurs when rec_valid && rec_ready.
  - rec_valid = (fill_level != 0).
  - rec_idx and rec_reports show the head entry combinationally from the FIFO storage.
  - Head is held stable while rec_valid && !rec_ready.
- Empty FIFO: a record pushed in cycle t is visible at the head (rec_valid=1) in cycle t+1. Latency report_vec->rec_valid is 1 cycle; symbol presented->rec_valid is 2 cycles.
- rec_ready while empty: ignored; pointers do not move.
- fill_level:
  - +1 on an accepted push without pop.
  - -1 on a pop without push.
  - Unchanged on push plus pop, or on neither.
- Pointers: read/write pointers of log2(DEPTH) bits wrap naturally. Full/empty are derived from the registered count, not from pointer compare.
- overflow and drop_count clear only on reset.

Decomposition:
- Package ltl_report_pkg holds:
  - a function computing the fill_level width from DEPTH;
  - a parameterised record typedef {idx, reports} with helper width constants;
  - the default parameter values, shared with the cluster wrapper.
- One sub-module: ltl_report_fifo, a synchronous single-clock FIFO.
  - Ports: clk, reset, push, push_data, pop, head_data, count.
  - Implements the full-with-pop acceptance rule.
- The collector itself holds the counter, alignment register, capture logic and drop accounting.

Test Plan:
- Reset then run=1 for 5 cycles, report_vec=4'b0000 throughout -> rec_valid stays 0, fill_level=0, no drops.
- Run symbols 0..9; drive report_vec=4'b0010 in the cycle after symbol 3 and 4'b1001 after symbol 7; rec_ready=1 -> records (idx=3, 0010) then (idx=7, 1001), each with rec_valid 1 cycle after capture.
- rec_ready=0; 10 consecutive reporting symbols, DEPTH=8 -> fill_level=8, overflow=1, drop_count=2. Then rec_ready=1 -> idx 0..7 drain in order, head held while stalled.
- Full FIFO, rec_ready=1 and a new report in the same cycle -> push accepted, fill_level stays 8, drop_count unchanged.
- Preload sym_cnt near wrap (IDX_W=4), run 20 symbols with reports at indices 14, 15, 0, 1 -> rec_idx sequence 14, 15, 0, 1.
- Reset asserted with 3 records buffered and overflow=1 -> next cycle rec_valid=0, fill_level=0, overflow=0, drop_count=0; next symbol index is 0.

Source files
------------

// File: rtl/ltl_report_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ltl_report_pkg
// Brief    : Shared defaults, record layout and width helpers for the
//            ltl report collector and its cluster wrapper.
// Revision : 1.0
// ============================================================================
package ltl_report_pkg;

  localparam int c_default_num_reports = 4;
  localparam int c_default_idx_w       = 32;
  localparam int c_default_depth       = 8;
  localparam int c_default_drop_w      = 16;

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int fill_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int rec_width(input int idx_w, input int num_reports);
    return idx_w + num_reports;
  endfunction

  localparam int c_default_rec_w = rec_width(c_default_idx_w, c_default_num_reports);

  typedef struct packed {
    logic [c_default_idx_w-1:0]       idx;
    logic [c_default_num_reports-1:0] reports;
  } report_rec_t;

endpackage
`default_nettype wire

// File: rtl/ltl_report_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ltl_report_fifo
// Brief    : Single-clock FIFO with a count-based full/empty decision; a push
//            into a full FIFO is accepted when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module ltl_report_fifo
  import ltl_report_pkg::*;
#(
  parameter int WIDTH = c_default_rec_w,
  parameter int DEPTH = c_default_depth
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic [fill_width(DEPTH)-1:0]  count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = fill_width(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_pop_fire;
  logic               w_push_fire;

  always_comb begin
    w_pop_fire  = pop && (r_count != '0);
    w_push_fire = push && ((r_count < c_cnt_w'(DEPTH)) || w_pop_fire);
  end

  // When full, wr_ptr == rd_ptr: the slot being vacated by the pop takes the new tail.
  always_ff @(posedge clk) begin
    if (w_push_fire) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_fire) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop_fire) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push_fire, w_pop_fire})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign head_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/ltl_report_collector.sv
`default_nettype none
// ============================================================================
// Module   : ltl_report_collector
// Brief    : Tags non-zero automaton report vectors with their symbol index,
//            buffers them for the monitor and accounts for dropped records.
// Revision : 1.0
// ============================================================================
module ltl_report_collector
  import ltl_report_pkg::*;
#(
  parameter int NUM_REPORTS = c_default_num_reports,
  parameter int IDX_W       = c_default_idx_w,
  parameter int DEPTH       = c_default_depth,
  parameter int DROP_W      = c_default_drop_w
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [NUM_REPORTS-1:0]        report_vec,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [IDX_W-1:0]              rec_idx,
  output logic [NUM_REPORTS-1:0]        rec_reports,
  output logic [fill_width(DEPTH)-1:0]  fill_level,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int c_cnt_w = fill_width(DEPTH);
  localparam int c_rec_w = rec_width(IDX_W, NUM_REPORTS);

  typedef struct packed {
    logic [IDX_W-1:0]       idx;
    logic [NUM_REPORTS-1:0] reports;
  } rec_t;

  logic [IDX_W-1:0]  r_sym_cnt;
  logic [IDX_W-1:0]  r_idx_q;
  logic              r_run_q;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;

  rec_t              w_push_rec;
  rec_t              w_head_rec;
  logic              w_push_req;
  logic              w_pop;
  logic              w_drop;

  // report_vec lags the consumed symbol by one cycle, hence run_q/idx_q qualify it.
  always_comb begin
    w_push_req         = r_run_q && (report_vec != '0);
    w_pop              = rec_valid && rec_ready;
    w_drop             = w_push_req && !((fill_level < c_cnt_w'(DEPTH)) || w_pop);
    w_push_rec.idx     = r_idx_q;
    w_push_rec.reports = report_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sym_cnt    <= '0;
      r_idx_q      <= '0;
      r_run_q      <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_run_q <= run;
      if (run) begin
        r_idx_q   <= r_sym_cnt;
        r_sym_cnt <= r_sym_cnt + IDX_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + DROP_W'(1);
        end
      end
    end
  end

  ltl_report_fifo #(
    .WIDTH (c_rec_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push_req),
    .push_data (w_push_rec),
    .pop       (w_pop),
    .head_data (w_head_rec),
    .count     (fill_level)
  );

  assign rec_valid   = (fill_level != '0);
  assign rec_idx     = w_head_rec.idx;
  assign rec_reports = w_head_rec.reports;
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;

endmodule
`default_nettype wire
